escalonador_uart_jogo: RTL
==========================

ESCALONADOR_UART_JOGO -- requirements
Module: escalonador_uart_jogo

Interface
REQ-001 The block SHALL have no parameters; the frame length (7 bytes) and encoding are fixed.
REQ-002 The block SHALL have port `clock`, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `enviar`, input, 1 bit: request to transmit one status frame, sampled every cycle.
REQ-005 The block SHALL have port `macro`, input, 4 bits: macro-board index.
REQ-006 The block SHALL have port `micro`, input, 4 bits: micro-cell index.
REQ-007 The block SHALL have port `estado`, input, 4 bits: game-controller state code.
REQ-008 The block SHALL have port `resultado_macro`, input, 2 bits: macro result (0..3).
REQ-009 The block SHALL have port `resultado_jogo`, input, 2 bits: game result (0..3).
REQ-010 The block SHALL have port `tx_pronto`, input, 1 bit: the byte transmitter is idle and can accept a byte.
REQ-011 The block SHALL have port `tx_dado`, output, 8 bits: the byte currently offered to the transmitter.
REQ-012 The block SHALL have port `tx_partida`, output, 1 bit: one-cycle start strobe to the transmitter.
REQ-013 The block SHALL have port `ocupado`, output, 1 bit: high in every state except OCIOSO.
REQ-014 The block SHALL have port `fim_envio`, output, 1 bit: one-cycle pulse when a frame completes.
REQ-015 The block SHALL have port `db_estado`, output, 3 bits: current FSM state code, for debug.

Function
REQ-016 The FSM SHALL have these states and codes: OCIOSO=0, CARREGA=1, ENVIA=2, AGUARDA_ACEITE=3, AGUARDA_FIM=4, CONCLUI=5.
REQ-017 In CARREGA, the block SHALL snapshot all five field inputs, clear the byte index to 0, and go to ENVIA; the frame SHALL then use only the snapshot.
REQ-018 Frame byte index 0..6 SHALL be, in order:
- index 0: 0x23 ('#')
- index 1: hex(macro)
- index 2: hex(micro)
- index 3: hex(estado)
- index 4: 0x30+resultado_macro
- index 5: 0x30+resultado_jogo
- index 6: 0x0A
REQ-019 hex(v) SHALL be 0x30+v for v=0..9 and 0x41+(v-10) for v=10..15, i.e. uppercase ASCII.
REQ-020 tx_dado SHALL equal the byte at the current index while in ENVIA, AGUARDA_ACEITE or AGUARDA_FIM, and 0x00 otherwise.
REQ-021 tx_partida SHALL be combinational: 1 exactly when the state is ENVIA and tx_pronto=1; in that same cycle the FSM SHALL go to AGUARDA_ACEITE.
REQ-022 In ENVIA with tx_pronto=0, the FSM SHALL hold without strobing.
REQ-023 AGUARDA_ACEITE SHALL hold until tx_pronto=0, then go to AGUARDA_FIM.
REQ-024 AGUARDA_FIM SHALL hold until tx_pronto=1; then:
- if the index is 6, go to CONCLUI;
- otherwise increment the index and go to ENVIA.
REQ-025 CONCLUI SHALL last one cycle, drive fim_envio=1, and go to CARREGA if the pending flag is set (clearing the flag), else to OCIOSO.
REQ-026 In OCIOSO, enviar=1 SHALL move the FSM to CARREGA on the next edge; the latency from enviar to the first tx_partida SHALL be 2 cycles when tx_pronto is held 1.
REQ-027 enviar=1 in any state other than OCIOSO SHALL set a one-deep pending flag; further requests while the flag is set SHALL be merged into it and not counted.
REQ-028 enviar=1 in the same cycle that CONCLUI clears the flag SHALL leave the flag set, so that the new request is not lost.
REQ-029 Exactly 7 tx_partida strobes SHALL occur per frame, and the byte index SHALL never exceed 6.
REQ-030 The block SHALL NOT apply a timeout; a transmitter stuck low or stuck high holds the FSM in its current state indefinitely.

Reset
REQ-031 While reset=0 the block SHALL asynchronously force: state OCIOSO, index 0, pending flag 0, snapshot 0, tx_dado=0x00, tx_partida=0, ocupado=0, fim_envio=0, db_estado=0.
REQ-032 Reset mid-frame SHALL abort the frame with no further strobes and no fim_envio pulse, and SHALL discard any pending request.
REQ-033 After reset release, the first enviar SHALL be processed normally.

Verification
REQ-034 Inputs macro=4, micro=0xB, estado=0xA, resultado_macro=1, resultado_jogo=2, with a transmitter model whose tx_pronto drops 1 cycle after the strobe and stays low 3 cycles; pulse enviar -> bytes 23 34 42 41 31 32 0A, 7 strobes, one fim_envio.
REQ-035 tx_pronto held 0 for 20 cycles in ENVIA -> no strobe and db_estado=2 throughout; tx_pronto rises -> strobe in that same cycle.
REQ-036 Change the field inputs right after CARREGA -> the transmitted frame still carries the snapshot values.
REQ-037 Three enviar pulses during a frame -> exactly two frames total, and the second starts one cycle after CONCLUI via CARREGA.
REQ-038 reset=0 asserted after the 3rd strobe -> outputs reach reset values immediately, with no fim_envio; a new enviar afterwards -> a complete 7-byte frame.

Source files
------------

// File: rtl/escalonador_uart_jogo.sv
`default_nettype none
// ============================================================================
// Module   : escalonador_uart_jogo
// Brief    : Sequences one 7-byte ASCII game-status frame into a byte UART.
// Revision : 1.0 - initial release
// ============================================================================
module escalonador_uart_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [3:0] macro,
  input  logic [3:0] micro,
  input  logic [3:0] estado,
  input  logic [1:0] resultado_macro,
  input  logic [1:0] resultado_jogo,
  input  logic       tx_pronto,
  output logic [7:0] tx_dado,
  output logic       tx_partida,
  output logic       ocupado,
  output logic       fim_envio,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    CARREGA        = 3'd1,
    ENVIA          = 3'd2,
    AGUARDA_ACEITE = 3'd3,
    AGUARDA_FIM    = 3'd4,
    CONCLUI        = 3'd5
  } estado_t;

  localparam logic [2:0] c_ULTIMO_INDICE = 3'd6;
  localparam logic [7:0] c_INICIO        = 8'h23;
  localparam logic [7:0] c_FIM_LINHA     = 8'h0A;
  localparam logic [7:0] c_ASCII_ZERO    = 8'h30;

  estado_t    r_estado_fsm;
  estado_t    w_prox_estado;
  logic [2:0] r_indice;
  logic [2:0] w_prox_indice;
  logic       r_pendente;
  logic       w_prox_pendente;

  logic [3:0] r_macro;
  logic [3:0] r_micro;
  logic [3:0] r_estado;
  logic [1:0] r_res_macro;
  logic [1:0] r_res_jogo;

  logic [7:0] w_byte;
  logic       w_em_envio;

  // Uppercase hex digit: 'A'..'F' is 0x37 + v for v >= 10.
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) begin
      return c_ASCII_ZERO + {4'h0, v};
    end
    return 8'h37 + {4'h0, v};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado_fsm <= OCIOSO;
      r_indice     <= 3'd0;
      r_pendente   <= 1'b0;
      r_macro      <= 4'd0;
      r_micro      <= 4'd0;
      r_estado     <= 4'd0;
      r_res_macro  <= 2'd0;
      r_res_jogo   <= 2'd0;
    end else begin
      r_estado_fsm <= w_prox_estado;
      r_indice     <= w_prox_indice;
      r_pendente   <= w_prox_pendente;
      if (r_estado_fsm == CARREGA) begin
        r_macro     <= macro;
        r_micro     <= micro;
        r_estado    <= estado;
        r_res_macro <= resultado_macro;
        r_res_jogo  <= resultado_jogo;
      end
    end
  end

  always_comb begin
    w_prox_estado = r_estado_fsm;
    w_prox_indice = r_indice;
    tx_partida    = 1'b0;
    case (r_estado_fsm)
      // A leftover pending flag can only appear here if enviar arrived
      // during CONCLUI with no earlier request queued.
      OCIOSO: begin
        if (enviar || r_pendente) begin
          w_prox_estado = CARREGA;
        end
      end
      CARREGA: begin
        w_prox_indice = 3'd0;
        w_prox_estado = ENVIA;
      end
      ENVIA: begin
        if (tx_pronto) begin
          tx_partida    = 1'b1;
          w_prox_estado = AGUARDA_ACEITE;
        end
      end
      AGUARDA_ACEITE: begin
        if (!tx_pronto) begin
          w_prox_estado = AGUARDA_FIM;
        end
      end
      AGUARDA_FIM: begin
        if (tx_pronto) begin
          if (r_indice == c_ULTIMO_INDICE) begin
            w_prox_estado = CONCLUI;
          end else begin
            w_prox_indice = r_indice + 3'd1;
            w_prox_estado = ENVIA;
          end
        end
      end
      CONCLUI: begin
        w_prox_estado = r_pendente ? CARREGA : OCIOSO;
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // A new request in the consuming cycle wins over the clear.
  always_comb begin
    w_prox_pendente = r_pendente;
    if ((r_estado_fsm == CONCLUI || r_estado_fsm == OCIOSO) && r_pendente) begin
      w_prox_pendente = 1'b0;
    end
    if (enviar && r_estado_fsm != OCIOSO) begin
      w_prox_pendente = 1'b1;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_indice)
      3'd0:    w_byte = c_INICIO;
      3'd1:    w_byte = hex_ascii(r_macro);
      3'd2:    w_byte = hex_ascii(r_micro);
      3'd3:    w_byte = hex_ascii(r_estado);
      3'd4:    w_byte = c_ASCII_ZERO + {6'd0, r_res_macro};
      3'd5:    w_byte = c_ASCII_ZERO + {6'd0, r_res_jogo};
      3'd6:    w_byte = c_FIM_LINHA;
      default: w_byte = 8'h00;
    endcase
  end

  assign w_em_envio = (r_estado_fsm == ENVIA) ||
                      (r_estado_fsm == AGUARDA_ACEITE) ||
                      (r_estado_fsm == AGUARDA_FIM);

  assign tx_dado   = w_em_envio ? w_byte : 8'h00;
  assign ocupado   = (r_estado_fsm != OCIOSO);
  assign fim_envio = (r_estado_fsm == CONCLUI);
  assign db_estado = r_estado_fsm;

endmodule
`default_nettype wire
